// File: rtl/pipelined_right_barrel_shifter_pkg.sv
// Shared definitions for the pipelined right barrel shifter.
// Holds the shift-mode encodings and the fill-bit helper used by every stage.
// Mode 2'b10 rotates only when BARREL_ROTATE_EN is defined; otherwise it is
// treated as a logical shift, as is the reserved mode 2'b11.
package pipelined_right_barrel_shifter_pkg;

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;

  // Bit shifted into the vacated MSBs: the carried sign for arithmetic, else 0.
  function automatic logic fill_bit(input logic [1:0] mode, input logic sign);
    return (mode == MODE_ASR) ? sign : 1'b0;
  endfunction

endpackage

// File: rtl/pipelined_right_barrel_shifter_barrel_shr_stage.sv
// One registered stage of the right barrel shifter.
// Shifts right by 2**STAGE when its shift-amount bit is set, and holds
// valid/data/shift/mode/sign with elastic advance logic.
// BARREL_ROTATE_EN adds the rotate-right path for mode 2'b10; without it
// no rotate mux exists and mode 2'b10 fills with zero.
module barrel_shr_stage
  import pipelined_right_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3,
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic [SHW-1:0]   prev_sh,
  input  logic [1:0]       prev_mode,
  input  logic             prev_sign,
  input  logic             next_adv,
  output logic             adv,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [SHW-1:0]   sh,
  output logic [1:0]       mode,
  output logic             sign
);

  localparam int SHIFT = 1 << STAGE;

  logic             v_q, v_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   sh_q, sh_d;
  logic [1:0]       mode_q, mode_d;
  logic             sign_q, sign_d;

  logic             fill;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] stage_data;

  // Fixed-distance shift of the predecessor's word, selected by this stage's bit
  always_comb begin
    fill    = fill_bit(prev_mode, prev_sign);
    shifted = {{SHIFT{fill}}, prev_data[WIDTH-1:SHIFT]};
`ifdef BARREL_ROTATE_EN
    if (prev_mode == MODE_ROR) begin
      shifted = {prev_data[SHIFT-1:0], prev_data[WIDTH-1:SHIFT]};
    end
`endif
    stage_data = prev_sh[STAGE] ? shifted : prev_data;
  end

  // An empty stage can always take a word, so bubbles collapse under stall
  assign adv = ~v_q | next_adv;

  // Load from the predecessor whenever this stage may advance
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    sh_d   = sh_q;
    mode_d = mode_q;
    sign_d = sign_q;
    if (adv) begin
      v_d = prev_valid;
      if (prev_valid) begin
        data_d = stage_data;
        sh_d   = prev_sh;
        mode_d = prev_mode;
        sign_d = prev_sign;
      end
    end
  end

  // Stage register; reset empties the stage and clears its word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= 1'b0;
      data_q <= '0;
      sh_q   <= '0;
      mode_q <= MODE_LSR;
      sign_q <= 1'b0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      sh_q   <= sh_d;
      mode_q <= mode_d;
      sign_q <= sign_d;
    end
  end

  assign valid = v_q;
  assign data  = data_q;
  assign sh    = sh_q;
  assign mode  = mode_q;
  assign sign  = sign_q;

endmodule

// File: rtl/pipelined_right_barrel_shifter.sv
// Pipelined right barrel shifter: SHW registered stages, stage k shifts by 2**k.
// Logical and arithmetic shifts; rotate-right on mode 2'b10 when
// BARREL_ROTATE_EN is defined. Valid/ready on both sides, no skid buffer:
// in_ready is combinational from out_ready through the stage chain.
module pipelined_right_barrel_shifter
  import pipelined_right_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_sh,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Index 0 is the input side, index k+1 is the register of stage k
  logic [SHW:0]            v_s;
  logic [SHW:0][WIDTH-1:0] data_s;
  logic [SHW:0][SHW-1:0]   sh_s;
  logic [SHW:0][1:0]       mode_s;
  logic [SHW:0]            sign_s;

  logic ready_q, ready_d;
  logic unused_tail;

  // Input side stays closed until the first clock after reset releases
  always_comb begin
    ready_d = 1'b1;
  end

  // Post-reset ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end

  assign v_s[0]    = in_valid & ready_q;
  assign data_s[0] = in_data;
  assign sh_s[0]   = in_sh;
  assign mode_s[0] = in_mode;
  assign sign_s[0] = in_data[WIDTH-1];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic adv;
    logic next_adv;

    if (k == SHW - 1) begin : g_last
      assign next_adv = out_ready;
    end else begin : g_mid
      assign next_adv = g_stage[k+1].adv;
    end

    barrel_shr_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .STAGE (k)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .prev_valid (v_s[k]),
      .prev_data  (data_s[k]),
      .prev_sh    (sh_s[k]),
      .prev_mode  (mode_s[k]),
      .prev_sign  (sign_s[k]),
      .next_adv   (next_adv),
      .adv        (adv),
      .valid      (v_s[k+1]),
      .data       (data_s[k+1]),
      .sh         (sh_s[k+1]),
      .mode       (mode_s[k+1]),
      .sign       (sign_s[k+1])
    );
  end

  assign in_ready  = ready_q & g_stage[0].adv;
  assign out_valid = v_s[SHW];
  assign out_data  = data_s[SHW];

  // Side-band of the final stage has no consumer
  assign unused_tail = ^{sh_s[SHW], mode_s[SHW], sign_s[SHW]};

endmodule

// File: tb/tb_pipelined_right_barrel_shifter.sv
// Self-checking bench for pipelined_right_barrel_shifter (WIDTH=8, SHW=3).
// Honours BARREL_ROTATE_EN for mode 2'b10 expectations.
module tb_pipelined_right_barrel_shifter;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_sh;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int total = 0;
  int bad   = 0;
  int out_count = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] d;
    logic [2:0] sh;
    logic [1:0] m;
    logic [7:0] e;
  } vec_t;

  vec_t tbl[8];

  pipelined_right_barrel_shifter #(.WIDTH(8), .SHW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sh     (in_sh),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: extend the operand to 16 bits with the right upper half and take a window
  function automatic logic [7:0] ref_shr(input logic [7:0] d, input logic [2:0] sh, input logic [1:0] m);
    logic [15:0] ext;
    case (m)
      2'd1: ext = {{8{d[7]}}, d};
`ifdef BARREL_ROTATE_EN
      2'd2: ext = {d, d};
`endif
      default: ext = {8'h00, d};
    endcase
    return ext[sh +: 8];
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {24'h0, out_data}, 32'hFFFF_FFFF);
        end else begin
          check("scoreboard", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
        end
        out_count++;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_shr(in_data, in_sh, in_mode));
    end
  end

  always @(posedge rst) exp_q.delete();

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_one(input vec_t v, input string name);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = v.d; in_sh = v.sh; in_mode = v.m;
    @(negedge clk);
    check({name, "_in_ready"}, {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({name, "_latency"}, n, 3);
    check({name, "_data"}, {24'h0, out_data}, {24'h0, v.e});
  endtask

  task automatic drain(input string name);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int accepted;
    int base;
    int n;
    logic [7:0] stream_exp[8];
    logic [7:0] bp_data[3];

    tbl[0] = '{8'hB4, 3'd3, 2'd0, 8'h16};
    tbl[1] = '{8'hB4, 3'd3, 2'd1, 8'hF6};
    tbl[2] = '{8'h74, 3'd2, 2'd1, 8'h1D};
    tbl[3] = '{8'h80, 3'd7, 2'd1, 8'hFF};
`ifdef BARREL_ROTATE_EN
    tbl[4] = '{8'h81, 3'd1, 2'd2, 8'hC0};
`else
    tbl[4] = '{8'h81, 3'd1, 2'd2, 8'h40};
`endif
    tbl[5] = '{8'hA5, 3'd0, 2'd1, 8'hA5};
    tbl[6] = '{8'h5A, 3'd0, 2'd2, 8'h5A};
    tbl[7] = '{8'hC3, 3'd4, 2'd3, 8'h0C};
    stream_exp = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sh = 3'd0; in_mode = 2'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", {24'h0, out_data}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_low", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    check("post_rst_ready_high", {31'h0, in_ready}, 32'h1);

    // Directed vectors, one word at a time
    for (int i = 0; i < 8; i++) begin
      send_one(tbl[i], $sformatf("vec%0d", i));
    end
    drain("vectors");

    // Eight back-to-back words
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(posedge clk); #1;
          in_valid = 1'b1; in_data = 8'hFF; in_sh = 3'(i); in_mode = 2'd0;
          @(negedge clk);
          check("stream_in_ready", {31'h0, in_ready}, 32'h1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 30);
        for (int i = 0; i < 8; i++) begin
          check("stream_valid", {31'h0, out_valid}, 32'h1);
          check("stream_data", {24'h0, out_data}, {24'h0, stream_exp[i]});
          if (i < 7) @(negedge clk);
        end
      end
    join
    drain("stream");

    // Backpressure: pipeline fills with three words, then in_ready drops
    accepted = 0;
    base = out_count;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 8'hC8 + 8'(accepted);
      in_sh = 3'(accepted);
      in_mode = 2'd1;
      @(negedge clk);
      if (in_ready && accepted < 3) bp_data[accepted] = ref_shr(in_data, in_sh, in_mode);
      if (in_ready) accepted++;
    end
    check("bp_accepted", accepted, 3);
    check("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
    check("bp_out_valid_held", {31'h0, out_valid}, 32'h1);
    check("bp_head_data", {24'h0, out_data}, {24'h0, bp_data[0]});
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (out_count < base + 3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("bp_out_count", out_count - base, 3);
    drain("bp");

    // Reset with two words in flight
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h9C; in_sh = 3'd1; in_mode = 2'd1;
    @(posedge clk); #1;
    in_data = 8'h3E; in_sh = 3'd2; in_mode = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_pre_valid", {31'h0, out_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_out_data", {24'h0, out_data}, 32'h0);
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    base = out_count;
    repeat (10) @(negedge clk);
    check("mid_rst_no_stale", out_count - base, 0);
    check("mid_rst_ready_back", {31'h0, in_ready}, 32'h1);

    // Randomised traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      in_sh     = 3'($urandom_range(0, 7));
      in_mode   = 2'($urandom_range(0, 3));
    end
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_right_barrel_shifter.md
Name: pipelined_right_barrel_shifter

Overview:
- Right-shift counterpart to the team's 8-bit left barrel shifter.
- Three registered stages; stage k conditionally shifts right by 2^k.
- Supports logical and arithmetic right shift.
- Valid/ready handshake on input and output, so it drops into streaming datapaths with backpressure.

Parameters:
- WIDTH, 8, data width in bits.
- SHW, 3, shift-amount width; must equal log2(WIDTH); also equals the pipeline depth.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept an input this cycle.
- in_data  input  WIDTH  operand.
- in_sh  input  SHW  right-shift amount, 0..WIDTH-1.
- in_mode  input  2  00 logical, 01 arithmetic, 10 rotate (optional), 11 reserved.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.

Behaviour:
- Transfer rules: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Each stage register holds v_k, data_k, sh_k, mode_k. Shift amount and mode travel with the data.
- Stage k computes from its predecessor's data:
  - if sh bit k = 1: data >> 2^k, with vacated MSBs filled by the fill bit;
  - if sh bit k = 0: pass through unchanged.
- Fill bit: 0 for logical; the original operand MSB for arithmetic. The sign is captured at stage 0 and carried as a bit alongside the data.
- Stage k loads when its predecessor holds valid data and stage k may advance.
- Advance rule: stage k may advance when it is empty or stage k+1 may advance. The last stage may advance when out_ready.
- in_ready = stage 0 may advance (combinational from out_ready through the chain; no skid buffer).
- out_valid = v_2; out_data = data_2.
- Latency: result on out_valid exactly 3 cycles after input acceptance when out_ready stays high.
- Throughput: one word per cycle when out_ready stays high.
- Backpressure: out_ready low holds all occupied stages unchanged. Bubbles collapse: an empty stage still loads while downstream is stalled.
- Ordering: strictly in-order; no word lost or duplicated under any valid/ready pattern.
- in_data, in_sh and in_mode are sampled only on input transfer.
- Mode 11: treated as logical.
- Shift 0: output equals input for every mode.
- Reset:
  - All v_k cleared immediately, asynchronously; out_valid=0, out_data=0.
  - in_ready is 1 one cycle after reset deasserts; it is held 0 while rst is high.
  - In-flight words are discarded on reset mid-operation.

Optional Feature:
- Macro: BARREL_ROTATE_EN.
- Defined: mode 10 performs rotate-right; bits shifted out of the LSB re-enter at the MSB at each stage.
- Not defined: mode 10 behaves as logical shift. No rotate muxes are synthesised.

Decomposition:
- Shared header shifter_defs.vh, holding:
  - mode localparams MODE_LSR=2'b00, MODE_ASR=2'b01, MODE_ROR=2'b10;
  - the BARREL_ROTATE_EN guard.
- Sub-module barrel_shr_stage, parameterised by WIDTH, SHW and STAGE (shift = 2^STAGE):
  - one registered stage: shift mux, fill or rotate select, valid/ready logic;
  - instantiated SHW times in a generate loop.

Test Plan:
- Reset with out_ready=1; send 8'hB4, sh=3, mode=00 -> out_data=8'h16 exactly 3 cycles later; in_ready=1 throughout.
- Arithmetic:
  - 8'hB4, sh=3, mode=01 -> 8'hF6;
  - 8'h74, sh=2, mode=01 -> 8'h1D;
  - 8'h80, sh=7, mode=01 -> 8'hFF.
- Stream 8 back-to-back words, sh=0..7, in_data=8'hFF, mode=00 -> outputs FF,7F,3F,1F,0F,07,03,01 on 8 consecutive cycles.
- Hold out_ready=0 for 6 cycles while in_valid=1:
  - pipeline fills with 3 words, then in_ready=0;
  - release -> words emerge in order, none lost or duplicated.
- Assert rst for 1 cycle with 2 words in flight -> out_valid drops immediately; no stale word appears afterwards.
- With BARREL_ROTATE_EN: 8'h81, sh=1, mode=10 -> 8'hC0. Without the macro: same stimulus -> 8'h40.
